// File: rtl/game_countdown_timer.sv
// Round clock for the game: counts down from START_SECONDS in BCD on one-second ticks,
// with pause, restart, abort, a low-time warning and a one-shot expiry event.
module game_countdown_timer #(
   parameter int unsigned START_SECONDS = 120,
   parameter int unsigned WARN_SECONDS  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       one_sec_tick,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   output logic [3:0] bcd_hund,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones,
   output logic       running,
   output logic       warn,
   output logic       time_up,
   output logic       time_up_pulse
);

   localparam logic [3:0] ReloadHund = 4'((START_SECONDS / 100) % 10);
   localparam logic [3:0] ReloadTens = 4'((START_SECONDS / 10) % 10);
   localparam logic [3:0] ReloadOnes = 4'(START_SECONDS % 10);
   // Clamp so the 10-bit compare below never sees a truncated limit.
   localparam logic [9:0] WarnLimit  = 10'((WARN_SECONDS > 999) ? 999 : WARN_SECONDS);

   typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

   state_e     state_q, state_d;
   logic [3:0] hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
   logic [3:0] hund_dec, tens_dec, ones_dec;
   logic       running_q, running_d;
   logic       warn_q, warn_d;
   logic       time_up_q, time_up_d;
   logic       pulse_q, pulse_d;
   logic [9:0] remaining_d;
   logic       at_one;

   // BCD decrement by one second with borrow through tens and hundreds.
   always_comb begin
      hund_dec = hund_q;
      tens_dec = tens_q;
      ones_dec = ones_q - 4'd1;
      if (ones_q == 4'd0) begin
         ones_dec = 4'd9;
         tens_dec = tens_q - 4'd1;
         if (tens_q == 4'd0) begin
            tens_dec = 4'd9;
            hund_dec = hund_q - 4'd1;
         end
      end
   end

   assign at_one = (hund_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd1);

   always_comb begin
      state_d = state_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      pulse_d = 1'b0;
      if (abort) begin
         state_d = StIdle;
         hund_d  = ReloadHund;
         tens_d  = ReloadTens;
         ones_d  = ReloadOnes;
      end else if (start) begin
         state_d = StRun;
         hund_d  = ReloadHund;
         tens_d  = ReloadTens;
         ones_d  = ReloadOnes;
      end else begin
         unique case (state_q)
            StIdle: ;
            StRun: begin
               if (pause) begin
                  state_d = StPaused;
               end else if (one_sec_tick) begin
                  if (at_one) begin
                     state_d = StExpired;
                     hund_d  = 4'd0;
                     tens_d  = 4'd0;
                     ones_d  = 4'd0;
                     pulse_d = 1'b1;
                  end else begin
                     hund_d = hund_dec;
                     tens_d = tens_dec;
                     ones_d = ones_dec;
                  end
               end
            end
            StPaused: begin
               if (!pause) state_d = StRun;
            end
            StExpired: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      remaining_d = 10'(hund_d) * 10'd100 + 10'(tens_d) * 10'd10 + 10'(ones_d);
      running_d   = (state_d == StRun);
      time_up_d   = (state_d == StExpired);
      warn_d      = ((state_d == StRun) || (state_d == StPaused)) &&
                    (remaining_d != 10'd0) && (remaining_d <= WarnLimit);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         hund_q    <= ReloadHund;
         tens_q    <= ReloadTens;
         ones_q    <= ReloadOnes;
         running_q <= 1'b0;
         warn_q    <= 1'b0;
         time_up_q <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         hund_q    <= hund_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         running_q <= running_d;
         warn_q    <= warn_d;
         time_up_q <= time_up_d;
         pulse_q   <= pulse_d;
      end
   end

   assign bcd_hund      = hund_q;
   assign bcd_tens      = tens_q;
   assign bcd_ones      = ones_q;
   assign running       = running_q;
   assign warn          = warn_q;
   assign time_up       = time_up_q;
   assign time_up_pulse = pulse_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench for game_countdown_timer with the default 120 s start and 10 s warning.
module tb_game_countdown_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic       one_sec_tick, start, pause, abort;
   logic [3:0] bcd_hund, bcd_tens, bcd_ones;
   logic       running, warn, time_up, time_up_pulse;
   logic [11:0] digits;

   int tests = 0;
   int fails = 0;

   game_countdown_timer #(.START_SECONDS(120), .WARN_SECONDS(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .one_sec_tick (one_sec_tick),
      .start        (start),
      .pause        (pause),
      .abort        (abort),
      .bcd_hund     (bcd_hund),
      .bcd_tens     (bcd_tens),
      .bcd_ones     (bcd_ones),
      .running      (running),
      .warn         (warn),
      .time_up      (time_up),
      .time_up_pulse(time_up_pulse)
   );

   always #5 clk = ~clk;
   assign digits = {bcd_hund, bcd_tens, bcd_ones};

   function automatic logic [11:0] to_bcd(input int n);
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   // One clock: pulse inputs apply for exactly this edge; outputs sampled 1 ns after it.
   task automatic cyc(input logic s, input logic t, input logic a);
      start = s;
      one_sec_tick = t;
      abort = a;
      @(posedge clk);
      #1;
      start = 1'b0;
      one_sec_tick = 1'b0;
      abort = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      tests++;
      if (digits !== to_bcd(120) || running !== 1'b0 || warn !== 1'b0 || time_up !== 1'b0 ||
          time_up_pulse !== 1'b0) begin
         fails++;
         $display("FAIL reset: digits=%h run=%b warn=%b tu=%b tup=%b, want 120 0 0 0 0",
                  digits, running, warn, time_up, time_up_pulse);
      end
      cyc(1'b0, 1'b1, 1'b0);
      tests++;
      if (digits !== to_bcd(120) || running !== 1'b0) begin
         fails++;
         $display("FAIL idle_tick: digits=%h run=%b, want 120 0", digits, running);
      end
   endtask

   task automatic test_countdown;
      int pulses = 0;
      cyc(1'b1, 1'b0, 1'b0);
      tests++;
      if (digits !== to_bcd(120) || running !== 1'b1) begin
         fails++;
         $display("FAIL start: digits=%h run=%b, want 120 1", digits, running);
      end
      for (int i = 1; i <= 120; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         if (time_up_pulse === 1'b1) pulses++;
         tests++;
         if (digits !== to_bcd(120 - i) || time_up_pulse !== (i == 120) ||
             time_up !== (i == 120) || warn !== ((120 - i) >= 1 && (120 - i) <= 10) ||
             running !== (i != 120)) begin
            fails++;
            $display("FAIL countdown[%0d]: digits=%h tup=%b tu=%b warn=%b run=%b, want %h",
                     i, digits, time_up_pulse, time_up, warn, running, to_bcd(120 - i));
         end
         for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (time_up_pulse === 1'b1) pulses++;
         end
      end
      ticks(3);
      tests++;
      if (pulses != 1 || time_up !== 1'b1 || digits !== 12'h000 || warn !== 1'b0) begin
         fails++;
         $display("FAIL expiry: pulses=%0d tu=%b digits=%h warn=%b, want 1 1 000 0",
                  pulses, time_up, digits, warn);
      end
   endtask

   task automatic test_abort;
      cyc(1'b1, 1'b0, 1'b1);
      tests++;
      if (digits !== to_bcd(120) || time_up !== 1'b0 || running !== 1'b0) begin
         fails++;
         $display("FAIL abort: digits=%h tu=%b run=%b, want 120 0 0", digits, time_up, running);
      end
   endtask

   task automatic test_back_to_back_borrow;
      cyc(1'b1, 1'b0, 1'b0);
      ticks(20);
      tests++;
      if (digits !== 12'h100) begin
         fails++;
         $display("FAIL b2b_20: digits=%h, want 100", digits);
      end
      ticks(1);
      tests++;
      if (digits !== 12'h099) begin
         fails++;
         $display("FAIL borrow_100: digits=%h, want 099", digits);
      end
      ticks(89);
      tests++;
      if (digits !== 12'h010 || warn !== 1'b1) begin
         fails++;
         $display("FAIL at_010: digits=%h warn=%b, want 010 1", digits, warn);
      end
      ticks(1);
      tests++;
      if (digits !== 12'h009) begin
         fails++;
         $display("FAIL borrow_010: digits=%h, want 009", digits);
      end
   endtask

   task automatic test_warn_edge;
      cyc(1'b1, 1'b0, 1'b0);
      ticks(109);
      tests++;
      if (digits !== 12'h011 || warn !== 1'b0) begin
         fails++;
         $display("FAIL warn_011: digits=%h warn=%b, want 011 0", digits, warn);
      end
      ticks(1);
      tests++;
      if (digits !== 12'h010 || warn !== 1'b1) begin
         fails++;
         $display("FAIL warn_010: digits=%h warn=%b, want 010 1", digits, warn);
      end
   endtask

   task automatic test_pause;
      cyc(1'b1, 1'b0, 1'b0);
      ticks(63);
      pause = 1'b1;
      cyc(1'b0, 1'b1, 1'b0);
      tests++;
      if (digits !== 12'h057 || running !== 1'b0) begin
         fails++;
         $display("FAIL pause_enter: digits=%h run=%b, want 057 0", digits, running);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         cyc(1'b0, 1'b0, 1'b0);
      end
      tests++;
      if (digits !== 12'h057 || running !== 1'b0) begin
         fails++;
         $display("FAIL pause_hold: digits=%h run=%b, want 057 0", digits, running);
      end
      pause = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      tests++;
      if (running !== 1'b1 || digits !== 12'h057) begin
         fails++;
         $display("FAIL pause_exit: digits=%h run=%b, want 057 1", digits, running);
      end
      ticks(1);
      tests++;
      if (digits !== 12'h056) begin
         fails++;
         $display("FAIL pause_resume: digits=%h, want 056", digits);
      end
   endtask

   task automatic test_start_with_tick;
      ticks(23);
      tests++;
      if (digits !== 12'h033) begin
         fails++;
         $display("FAIL reach_033: digits=%h, want 033", digits);
      end
      cyc(1'b1, 1'b1, 1'b0);
      tests++;
      if (digits !== 12'h120 || running !== 1'b1) begin
         fails++;
         $display("FAIL start_tick: digits=%h run=%b, want 120 1", digits, running);
      end
   endtask

   task automatic test_reset_midrun;
      ticks(75);
      rst = 1'b0;
      cyc(1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      tests++;
      if (digits !== 12'h120 || running !== 1'b0 || warn !== 1'b0 || time_up !== 1'b0 ||
          time_up_pulse !== 1'b0) begin
         fails++;
         $display("FAIL rst_midrun: digits=%h run=%b warn=%b tu=%b, want 120 0 0 0",
                  digits, running, warn, time_up);
      end
      ticks(3);
      tests++;
      if (digits !== 12'h120 || running !== 1'b0) begin
         fails++;
         $display("FAIL rst_ignore: digits=%h run=%b, want 120 0", digits, running);
      end
      cyc(1'b1, 1'b0, 1'b0);
      ticks(1);
      tests++;
      if (digits !== 12'h119 || running !== 1'b1) begin
         fails++;
         $display("FAIL rst_restart: digits=%h run=%b, want 119 1", digits, running);
      end
   endtask

   initial begin
      rst = 1'b0;
      one_sec_tick = 1'b0;
      start = 1'b0;
      pause = 1'b0;
      abort = 1'b0;
      test_reset();
      test_countdown();
      test_abort();
      test_back_to_back_borrow();
      test_warn_edge();
      test_pause();
      test_start_with_tick();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
